// File: rtl/cardinal_noc_pkg.sv
// Shared Cardinal NoC definitions: flit width, big-endian header bit positions,
// output-port direction indices and the one-hot request type.
package cardinal_noc_pkg;

    localparam int DATA_WIDTH = 64;

    // Header bit positions, index 0 is the MSB of a [0:DATA_WIDTH-1] flit
    localparam int VC      = 0;
    localparam int DX      = 1;
    localparam int DY      = 2;
    localparam int HOPX_LO = 8;
    localparam int HOPX_HI = 11;
    localparam int HOPY_LO = 12;
    localparam int HOPY_HI = 15;

    localparam int N  = 0;
    localparam int E  = 1;
    localparam int S  = 2;
    localparam int W  = 3;
    localparam int PE = 4;

    typedef logic [0:4] req_t;

endpackage

// File: rtl/cardinal_vc_input_buffer_if.sv
// Link/crossbar bundle of one router input port. `dout` carries the rewritten
// outgoing flit (the name `do` is a reserved word in SystemVerilog).
interface cardinal_vc_input_buffer_if
    import cardinal_noc_pkg::*;
#(
    parameter int PACKET_SIZE = DATA_WIDTH
);
    logic                   si;
    logic [0:PACKET_SIZE-1] di;
    logic                   ro;
    req_t                   req;
    logic                   gnt;
    logic [0:PACKET_SIZE-1] dout;

    modport master (output si, di, gnt, input ro, req, dout);
    modport slave  (input si, di, gnt, output ro, req, dout);
endinterface

// File: rtl/cardinal_route_compute.sv
// Combinational dimension-ordered (X then Y) route and header rewrite for one flit.
// Shared by the input buffers and the PE injection path.
module cardinal_route_compute
    import cardinal_noc_pkg::*;
#(
    parameter int PACKET_SIZE = DATA_WIDTH
) (
    input  logic                   valid,
    input  logic [0:PACKET_SIZE-1] flit,
    output req_t                   req,
    output logic [0:PACKET_SIZE-1] flit_out
);

    logic [3:0] hop_x;
    logic [3:0] hop_y;

    assign hop_x = flit[HOPX_LO:HOPX_HI];
    assign hop_y = flit[HOPY_LO:HOPY_HI];

    always_comb begin
        req      = '0;
        flit_out = '0;
        if (valid) begin
            flit_out     = flit;
            flit_out[VC] = ~flit[VC];
            // Only the hop field that selected the port is consumed, so PE never underflows
            if (hop_x != 4'd0) begin
                req[flit[DX] ? W : E]        = 1'b1;
                flit_out[HOPX_LO:HOPX_HI] = hop_x - 4'd1;
            end else if (hop_y != 4'd0) begin
                req[flit[DY] ? N : S]        = 1'b1;
                flit_out[HOPY_LO:HOPY_HI] = hop_y - 4'd1;
            end else begin
                req[PE] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cardinal_vc_input_buffer.sv
// Two-VC input buffer of a Cardinal router port: the link writes VC[polarity],
// the crossbar reads VC[~polarity]. CARDINAL_IBUF_STATS_EN adds a saturating
// accepted-flit counter.
module cardinal_vc_input_buffer
    import cardinal_noc_pkg::*;
#(
    parameter int PACKET_SIZE = DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        polarity,
`ifdef CARDINAL_IBUF_STATS_EN
    output logic [15:0]                 flit_count,
`endif
    cardinal_vc_input_buffer_if.slave   link
);

    logic [1:0]                   full;
    logic [1:0][0:PACKET_SIZE-1]  data;
    logic                         rd_vc;
    logic                         wr_en;
    logic                         rd_en;

    assign rd_vc    = ~polarity;
    assign link.ro  = ~full[polarity];
    // si while not ready is dropped silently
    assign wr_en    = link.si && ~full[polarity];
    assign rd_en    = link.gnt && full[rd_vc];

    // Write and read always address different VCs, so both may fire together
    always_ff @(posedge clk) begin
        if (!reset) begin
            full <= '0;
            data <= '0;
        end else begin
            if (wr_en) begin
                data[polarity] <= link.di;
                full[polarity] <= 1'b1;
            end
            if (rd_en) begin
                full[rd_vc] <= 1'b0;
            end
        end
    end

    cardinal_route_compute #(
        .PACKET_SIZE (PACKET_SIZE)
    ) u_route (
        .valid    (full[rd_vc]),
        .flit     (data[rd_vc]),
        .req      (link.req),
        .flit_out (link.dout)
    );

`ifdef CARDINAL_IBUF_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            flit_count <= '0;
        end else if (wr_en && flit_count != 16'hFFFF) begin
            flit_count <= flit_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cardinal_vc_input_buffer.sv
// Scoreboard bench for cardinal_vc_input_buffer: directed cases plus random traffic
// checked against a queue-based model of the two VCs. Define CARDINAL_IBUF_STATS_EN for the counter.
module tb_cardinal_vc_input_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
`ifdef CARDINAL_IBUF_STATS_EN
    logic [15:0] flit_count;
`endif

    cardinal_vc_input_buffer_if #(.PACKET_SIZE(64)) link ();

    cardinal_vc_input_buffer #(.PACKET_SIZE(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .polarity   (polarity),
`ifdef CARDINAL_IBUF_STATS_EN
        .flit_count (flit_count),
`endif
        .link       (link)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: consume one hop along X first, then Y, else deliver locally; flip the VC bit
    function automatic void ref_route(input logic [63:0] f, output logic [4:0] r, output logic [63:0] o);
        int hx, hy;
        hx = int'((f >> 52) & 64'hF);
        hy = int'((f >> 48) & 64'hF);
        o  = f;
        if (hx != 0) begin
            r = f[62] ? 5'b00010 : 5'b01000;
            o = f - (64'd1 << 52);
        end else if (hy != 0) begin
            r = f[61] ? 5'b10000 : 5'b00100;
            o = f - (64'd1 << 48);
        end else begin
            r = 5'b00001;
        end
        o = o ^ (64'd1 << 63);
    endfunction

    // Scoreboard: accepted flits are queued per VC; the monitor pops on each granted presentation
    logic [63:0] vq[2][$];
    int          cnt_m    = 0;
    bit          seen_rst = 0;

    always @(negedge clk) begin
        logic [4:0]  er;
        logic [63:0] ed;
        int          wp, rp;
        bit          exp_ro;
        if (!reset) begin
            vq[0].delete();
            vq[1].delete();
            cnt_m    = 0;
            seen_rst = 1;
        end else if (seen_rst) begin
            wp     = int'(polarity);
            rp     = 1 - wp;
            exp_ro = (vq[wp].size() == 0);
            chk("mon_ro", 64'(link.ro), 64'(exp_ro));
`ifdef CARDINAL_IBUF_STATS_EN
            chk("mon_flit_count", 64'(flit_count), 64'(cnt_m));
`endif
            if (vq[rp].size() > 0) begin
                ref_route(vq[rp][0], er, ed);
                chk("mon_req", 64'(link.req), 64'(er));
                chk("mon_do", link.dout, ed);
                if (link.gnt) void'(vq[rp].pop_front());
            end else begin
                chk("mon_req_idle", 64'(link.req), 64'd0);
                chk("mon_do_idle", link.dout, 64'd0);
            end
            if (link.si && exp_ro) begin
                vq[wp].push_back(link.di);
                if (cnt_m < 16'hFFFF) cnt_m++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_flit();
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[55:52] = 4'($urandom_range(0, 2));
        d[51:48] = 4'($urandom_range(0, 2));
        return d;
    endfunction

    initial begin
        reset    = 1'b0;
        polarity = 1'b0;
        link.si  = 1'b1;
        link.di  = 64'hDEAD_BEEF_0123_4567;
        link.gnt = 1'b0;
        tick();
        polarity = 1'b1;
        tick();
        chk("reset_ro", 64'(link.ro), 64'd1);
        chk("reset_req", 64'(link.req), 64'd0);
        chk("reset_do", link.dout, 64'd0);
        polarity = 1'b0;
        #1;
        chk("reset_nothing_captured", 64'(link.req), 64'd0);

        // East route with hop_x = 3
        reset    = 1'b1;
        link.si  = 1'b1;
        link.di  = 64'h0030_0000_0000_0001;
        tick();
        polarity = 1'b1;
        link.si  = 1'b0;
        #1;
        chk("route_east_req", 64'(link.req), 64'(5'b01000));
        chk("route_east_do", link.dout, 64'h8020_0000_0000_0001);
        link.gnt = 1'b1;
        tick();
        polarity = 1'b0;
        link.gnt = 1'b0;
        #1;
        chk("route_east_freed_ro", 64'(link.ro), 64'd1);

        // Full VC: second write to the same VC is dropped, held flit (North) re-presented
        link.si  = 1'b1;
        link.di  = 64'h2001_0000_0000_00AA;
        tick();
        polarity = 1'b1;
        link.si  = 1'b0;
        tick();
        polarity = 1'b0;
        #1;
        chk("full_ro_low", 64'(link.ro), 64'd0);
        link.si  = 1'b1;
        link.di  = 64'h0F0F_5555_5555_5555;
        tick();
        polarity = 1'b1;
        link.si  = 1'b0;
        #1;
        chk("full_held_req", 64'(link.req), 64'(5'b10000));
        chk("full_held_do", link.dout, 64'hA000_0000_0000_00AA);
        link.gnt = 1'b1;
        tick();
        polarity = 1'b0;
        link.gnt = 1'b0;
        #1;
        chk("full_freed_ro", 64'(link.ro), 64'd1);

        // Arrival: both hops zero -> PE, hops untouched
        link.si  = 1'b1;
        link.di  = 64'h4000_1234_5678_9ABC;
        tick();
        polarity = 1'b1;
        link.si  = 1'b0;
        #1;
        chk("pe_req", 64'(link.req), 64'(5'b00001));
        chk("pe_do", link.dout, 64'hC000_1234_5678_9ABC);
        link.gnt = 1'b1;
        tick();

        // Back-to-back with gnt held: ready must never drop
        link.gnt = 1'b1;
        for (int i = 0; i < 24; i++) begin
            polarity = ~polarity;
            link.si  = 1'b1;
            link.di  = rand_flit();
            #1;
            chk("b2b_ro", 64'(link.ro), 64'd1);
            tick();
        end
        link.si = 1'b0;
        polarity = ~polarity;
        tick();
        polarity = ~polarity;
        tick();

        // Random traffic, occasional polarity stalls and a mid-run reset
        for (int i = 0; i < 500; i++) begin
            reset    = (i == 250) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) != 0) polarity = ~polarity;
            link.si  = ($urandom_range(0, 3) != 0);
            link.di  = rand_flit();
            link.gnt = $urandom_range(0, 1) == 1;
            tick();
        end
        reset = 1'b1;

`ifdef CARDINAL_IBUF_STATS_EN
        link.gnt = 1'b1;
        link.si  = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            polarity = ~polarity;
            link.di  = rand_flit();
            tick();
        end
        link.si = 1'b0;
        chk("stats_saturated", 64'(flit_count), 64'hFFFF);
`endif

        link.si  = 1'b0;
        link.gnt = 1'b0;
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
